// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command front end for a combinational 16-opcode ALU.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_opcode/a/b    command push interface
//   alu_en, alu_opcode, alu_a, alu_b       registered drive to the ALU
//   alu_result                             combinational ALU result
//   rsp_valid/rsp_ready, rsp_result/opcode/err  response handshake
//   busy, count                            activity and FIFO occupancy
module alu_cmd_sequencer #(
   parameter int DATA_W = 16,
   parameter int RES_W  = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_opcode,
   input  logic [DATA_W-1:0]        cmd_a,
   input  logic [DATA_W-1:0]        cmd_b,
   output logic                     alu_en,
   output logic [3:0]               alu_opcode,
   output logic [DATA_W-1:0]        alu_a,
   output logic [DATA_W-1:0]        alu_b,
   input  logic [RES_W-1:0]         alu_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [RES_W-1:0]         rsp_result,
   output logic [3:0]               rsp_opcode,
   output logic                     rsp_err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
   state_t state_q, state_d;
   logic [4+2*DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] count_q;
   logic [3:0] h_op;
   logic [DATA_W-1:0] h_a, h_b;
   logic push, pop, trap;
   logic alu_en_q, alu_en_d;
   logic [3:0] alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [RES_W-1:0] rsp_result_q, rsp_result_d;
   logic [3:0] rsp_opcode_q, rsp_opcode_d;
   // ready comes from the registered count only, so a pop never frees space in the same cycle
   assign cmd_ready = (count_q < (AW+1)'(DEPTH)) && !rst;
   assign push = cmd_valid && cmd_ready;
   assign pop = (state_q == IDLE) && (count_q != '0);
   assign {h_op, h_a, h_b} = mem_q[rd_q];
   assign trap = (h_op == 4'hF) && (h_b == '0);
   assign alu_en = alu_en_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a = alu_a_q;
   assign alu_b = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_opcode = rsp_opcode_q;
   assign rsp_err = rsp_err_q;
   assign count = count_q;
   assign busy = (state_q != IDLE) || (count_q != '0);
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= {cmd_opcode, cmd_a, cmd_b};
   always_comb begin
      state_d = state_q;
      alu_en_d = 1'b0;
      alu_opcode_d = '0;
      alu_a_d = '0;
      alu_b_d = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_opcode_d = rsp_opcode_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         IDLE: if (pop) begin
            if (trap) begin
               state_d = HOLD;
               rsp_valid_d = 1'b1;
               rsp_err_d = 1'b1;
               rsp_result_d = '0;
               rsp_opcode_d = 4'hF;
            end else begin
               state_d = ISSUE;
               alu_en_d = 1'b1;
               alu_opcode_d = h_op;
               alu_a_d = h_a;
               alu_b_d = h_b;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
            alu_en_d = 1'b1;
            alu_opcode_d = alu_opcode_q;
            alu_a_d = alu_a_q;
            alu_b_d = alu_b_q;
         end
         CAPTURE: begin
            state_d = HOLD;
            rsp_valid_d = 1'b1;
            rsp_result_d = alu_result;
            rsp_opcode_d = alu_opcode_q;
            rsp_err_d = 1'b0;
         end
         default: if (rsp_ready) begin
            state_d = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
         alu_en_q <= 1'b0;
         alu_opcode_q <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_result_q <= '0;
         rsp_opcode_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q <= push ? wr_q + AW'(1) : wr_q;
         rd_q <= pop ? rd_q + AW'(1) : rd_q;
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
         alu_en_q <= alu_en_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_opcode_q <= rsp_opcode_d;
         rsp_err_q <= rsp_err_d;
      end
   end
endmodule
